// File: rtl/seg_scan_display.sv
// Binary-to-BCD (double-dabble) converter that drives a 4-digit multiplexed 7-segment display.
// A value is converted once per load strobe, and the display scans the digits continuously.
module seg_scan_display #(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] din,
   output logic        busy,
   output logic        ovf,
   output logic [6:0]  seg,
   output logic [3:0]  an
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;

   typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

   state_t           state, state_next;
   logic [15:0]      bin;
   logic [19:0]      bcd;
   logic [19:0]      bcd_adj;
   logic [35:0]      shifted;
   logic [3:0]       cnt;
   logic [3:0][6:0]  disp;
   logic [3:0][6:0]  disp_new;
   logic             ovf_new;
   logic [PW-1:0]    pre;
   logic [1:0]       idx;
   logic [1:0]       idx_next;
   logic             wrap;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'b1000000;
         4'd1:    decode = 7'b1111001;
         4'd2:    decode = 7'b0100100;
         4'd3:    decode = 7'b0110000;
         4'd4:    decode = 7'b0011001;
         4'd5:    decode = 7'b0010010;
         4'd6:    decode = 7'b0000010;
         4'd7:    decode = 7'b1111000;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0010000;
         default: decode = SEG_BLANK;
      endcase
   endfunction

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (load) state_next = CONV;
         CONV:    if (cnt == 4'd15) state_next = LATCH;
         LATCH:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // One double-dabble step: correct nibbles >= 5, then shift the combined register left.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 5; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      shifted = {bcd_adj, bin} << 1;
   end

   // Leading zeros are blanked from the thousands digit downwards; units always shows.
   always_comb begin
      ovf_new  = (bcd[19:16] != 4'd0);
      disp_new = {4{SEG_DASH}};
      if (!ovf_new) begin
         disp_new[0] = decode(bcd[3:0]);
         disp_new[1] = (bcd[15:4]  == 12'd0) ? SEG_BLANK : decode(bcd[7:4]);
         disp_new[2] = (bcd[15:8]  == 8'd0)  ? SEG_BLANK : decode(bcd[11:8]);
         disp_new[3] = (bcd[15:12] == 4'd0)  ? SEG_BLANK : decode(bcd[15:12]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin  <= '0;
         bcd  <= '0;
         cnt  <= '0;
         ovf  <= 1'b0;
         disp <= {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_ZERO};
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  bin <= din;
                  bcd <= '0;
                  cnt <= '0;
               end
            end
            CONV: begin
               bcd <= shifted[35:16];
               bin <= shifted[15:0];
               cnt <= cnt + 4'd1;
            end
            LATCH: begin
               ovf  <= ovf_new;
               disp <= disp_new;
            end
            default: ;
         endcase
      end
   end

   assign wrap     = (pre == PRE_MAX);
   assign idx_next = wrap ? idx + 2'd1 : idx;

   // an/seg are registered from the upcoming index so both switch on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= '0;
         idx <= '0;
         an  <= 4'b1110;
         seg <= SEG_ZERO;
      end else begin
         pre <= wrap ? '0 : pre + 1'b1;
         idx <= idx_next;
         an  <= ~(4'b0001 << idx_next);
         seg <= disp[idx_next];
      end
   end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: stimulus queues expected digits, a monitor
// checks them after each conversion finishes.
module tb_seg_scan_display;

   localparam int SCAN_DIV = 4;
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] DASH  = 7'b0111111;
   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000;

   typedef struct packed {
      logic       ovf;
      logic [6:0] d3;
      logic [6:0] d2;
      logic [6:0] d1;
      logic [6:0] d0;
   } result_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [15:0] din = '0;
   logic        busy;
   logic        ovf;
   logic [6:0]  seg;
   logic [3:0]  an;

   result_t exp_q[$];
   int check_count = 0;
   int pass_count  = 0;
   int done_count  = 0;
   int exp_done    = 0;

   seg_scan_display #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .din   (din),
      .busy  (busy),
      .ovf   (ovf),
      .seg   (seg),
      .an    (an)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
      check_count++;
      if (got === expv) pass_count++;
      else $display("[TB] FAIL %s: got %0b expected %0b", name, got, expv);
   endtask

   task automatic applyStimulus(input logic [15:0] value, input result_t expv, input bit expect_result);
      @(negedge clk);
      din  = value;
      load = 1'b1;
      if (expect_result) begin
         exp_q.push_back(expv);
         exp_done++;
      end
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic waitResult(input string tag);
      int n = 0;
      while (done_count < exp_done && n < 300) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_done"}, done_count, exp_done);
      repeat (4) @(negedge clk);
   endtask

   // Called right after reset release: expects value 0 shown while the digits rotate.
   task automatic checkResetScan(input string tag);
      #1;
      checkOutput({tag, "_busy"}, busy, 1'b0);
      checkOutput({tag, "_ovf"}, ovf, 1'b0);
      for (int d = 0; d < 4; d++) begin
         for (int k = 0; k < 4; k++) begin
            checkOutput({tag, "_an"}, an, 4'b1111 ^ (4'b0001 << d));
            checkOutput({tag, "_seg"}, seg, (d == 0) ? S0 : BLANK);
            @(negedge clk);
         end
      end
   endtask

   initial begin : monitor
      int busy_cycles;
      int d;
      result_t expv;
      logic [6:0] got [4];
      logic [3:0] seen;
      busy_cycles = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) busy_cycles = 0;
         else if (busy) busy_cycles++;
         else if (busy_cycles != 0) begin
            checkOutput("busy_len", busy_cycles, 17);
            busy_cycles = 0;
            if (exp_q.size() == 0) begin
               check_count++;
               $display("[TB] FAIL unexpected_result: conversion finished with nothing queued");
            end else begin
               expv = exp_q.pop_front();
               checkOutput("ovf", ovf, expv.ovf);
               seen = '0;
               for (int i = 0; i < 4; i++) got[i] = '0;
               @(negedge clk);
               for (int k = 0; k < 16; k++) begin
                  @(negedge clk);
                  case (an)
                     4'b1110: d = 0;
                     4'b1101: d = 1;
                     4'b1011: d = 2;
                     4'b0111: d = 3;
                     default: d = -1;
                  endcase
                  if (d >= 0) begin
                     got[d]  = seg;
                     seen[d] = 1'b1;
                  end
               end
               checkOutput("digits_seen", seen, 4'b1111);
               checkOutput("units", got[0], expv.d0);
               checkOutput("tens", got[1], expv.d1);
               checkOutput("hundreds", got[2], expv.d2);
               checkOutput("thousands", got[3], expv.d3);
            end
            done_count++;
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      checkResetScan("reset");

      applyStimulus(16'd33, result_t'{1'b0, BLANK, BLANK, S3, S3}, 1'b1);
      waitResult("d33");
      applyStimulus(16'd1234, result_t'{1'b0, S1, S2, S3, S4}, 1'b1);
      waitResult("d1234");
      applyStimulus(16'd65535, result_t'{1'b1, DASH, DASH, DASH, DASH}, 1'b1);
      waitResult("d65535");

      // Second load lands on the 5th busy cycle and must be dropped.
      applyStimulus(16'd50, result_t'{1'b0, BLANK, BLANK, S5, S0}, 1'b1);
      repeat (4) @(negedge clk);
      din  = 16'd7;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      waitResult("d50");

      applyStimulus(16'd0, result_t'{1'b0, BLANK, BLANK, BLANK, S0}, 1'b1);
      waitResult("d0");
      applyStimulus(16'd1005, result_t'{1'b0, S1, S0, S0, S5}, 1'b1);
      waitResult("d1005");
      applyStimulus(16'd9999, result_t'{1'b0, S9, S9, S9, S9}, 1'b1);
      waitResult("d9999");
      applyStimulus(16'd10000, result_t'{1'b1, DASH, DASH, DASH, DASH}, 1'b1);
      waitResult("d10000");
      applyStimulus(16'd907, result_t'{1'b0, BLANK, S9, S0, S7}, 1'b1);
      waitResult("d907");

      // Reset on the 8th conversion cycle aborts the 9999 conversion.
      applyStimulus(16'd9999, result_t'{1'b0, S9, S9, S9, S9}, 1'b0);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", busy, 1'b0);
      checkOutput("abort_an", an, 4'b1110);
      checkOutput("abort_seg", seg, S0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      checkResetScan("abort");

      // A load presented together with reset release is taken on the first edge.
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      din   = 16'd42;
      load  = 1'b1;
      exp_q.push_back(result_t'{1'b0, BLANK, BLANK, S4, S2});
      exp_done++;
      @(negedge clk);
      load = 1'b0;
      checkOutput("first_edge_busy", busy, 1'b1);
      waitResult("d42");

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
